// File: rtl/enemy_sprite_drawer.sv
`default_nettype none
// ============================================================================
// Module   : enemy_sprite_drawer
// Purpose  : Erases the enemy sprite at its old x and redraws it at the new x,
//            one pixel per clock, into a 160x120 3-bit VGA adapter port.
//            Optional macro SPRITE_MASK_EN selects an 8x8 bitmap for DRAW.
// Revision : 1.0 - initial release
// ============================================================================
module enemy_sprite_drawer #(
    parameter int         SPRITE_W     = 8,
    parameter int         SPRITE_H     = 8,
    parameter int         ENEMY_Y      = 4,
    parameter int         SCREEN_W     = 160,
    parameter logic [2:0] ENEMY_COLOUR = 3'b100,
    parameter logic [2:0] BG_COLOUR    = 3'b000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] x_val,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       draw_done
);

    localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST     = COL_W'(SPRITE_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(SPRITE_H - 1);
    localparam logic [8:0]       SCREEN_LIMIT = 9'(SCREEN_W);
    localparam logic [6:0]       Y_BASE       = 7'(ENEMY_Y);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       last_x;
    logic [7:0]       new_x;
    logic             first_draw;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    // Address stage between the scan counters and the registered VGA outputs
    logic             s1_valid;
    logic             s1_last;
    logic             s1_en;
    logic [8:0]       s1_sum;
    logic [ROW_W-1:0] s1_row;
    logic [2:0]       s1_colour;
    logic             s2_last;

    logic             scan_end;
    logic             mask_bit;
    logic [7:0]       base_x;

    assign scan_end = (col == COL_LAST) && (row == ROW_LAST);
    assign base_x   = (state == ERASE) ? last_x : new_x;

`ifdef SPRITE_MASK_EN
    logic [7:0] mask_row;

    always_comb begin
        mask_row = 8'h00;
        case (row)
            3'd0: mask_row = 8'h18;
            3'd1: mask_row = 8'h3C;
            3'd2: mask_row = 8'h7E;
            3'd3: mask_row = 8'hDB;
            3'd4: mask_row = 8'hFF;
            3'd5: mask_row = 8'h24;
            3'd6: mask_row = 8'h5A;
            3'd7: mask_row = 8'hA5;
        endcase
    end

    // Bitmap MSB is column 0
    assign mask_bit = mask_row[3'd7 - col];
`else
    assign mask_bit = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_x     <= 8'd0;
            new_x      <= 8'd0;
            first_draw <= 1'b1;
            col        <= '0;
            row        <= '0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_en      <= 1'b0;
            s1_sum     <= 9'd0;
            s1_row     <= '0;
            s1_colour  <= 3'd0;
            s2_last    <= 1'b0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 3'd0;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
            draw_done  <= 1'b0;
        end else begin
            // Clipped pixels still occupy their cycle; only the strobe is suppressed
            vga_plot <= s1_valid && s1_en && (s1_sum < SCREEN_LIMIT);
            if (s1_valid) begin
                vga_x      <= s1_sum[7:0];
                vga_y      <= Y_BASE + 7'(s1_row);
                vga_colour <= s1_colour;
            end
            s2_last   <= s1_valid && s1_last;
            draw_done <= s2_last;
            busy      <= (state != IDLE) || s1_valid || s2_last;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;

            case (state)
                IDLE: begin
                    if (first_draw || (x_val != last_x)) begin
                        new_x      <= x_val;
                        busy       <= 1'b1;
                        first_draw <= 1'b0;
                        state      <= first_draw ? DRAW : ERASE;
                    end
                end
                ERASE, DRAW: begin
                    s1_valid  <= 1'b1;
                    s1_sum    <= {1'b0, base_x} + 9'(col);
                    s1_row    <= row;
                    s1_colour <= (state == ERASE) ? BG_COLOUR : ENEMY_COLOUR;
                    s1_en     <= (state == ERASE) || mask_bit;
                    s1_last   <= (state == DRAW) && scan_end;

                    if (col == COL_LAST) begin
                        col <= '0;
                        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end

                    if (scan_end) begin
                        if (state == ERASE) begin
                            state <= DRAW;
                        end else begin
                            state  <= IDLE;
                            last_x <= new_x;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_enemy_sprite_drawer.sv
`default_nettype none
// ============================================================================
// Module   : tb_enemy_sprite_drawer
// Purpose  : Self-checking bench for enemy_sprite_drawer (honours SPRITE_MASK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_enemy_sprite_drawer;

    localparam int SPRITE_W = 8;
    localparam int SPRITE_H = 8;
    localparam int ENEMY_Y  = 4;
    localparam int SCREEN_W = 160;
    localparam int NPIX     = SPRITE_W * SPRITE_H;
    localparam int MAXC     = 20000;
`ifdef SPRITE_MASK_EN
    localparam int FG_FULL   = 36;
    localparam int FG_EDGE   = 7;
    localparam int FIRST_COL = 3;
`else
    localparam int FG_FULL   = 64;
    localparam int FG_EDGE   = 16;
    localparam int FIRST_COL = 0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] x_val = 8'd0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       draw_done;

    enemy_sprite_drawer dut (
        .clock      (clock),
        .reset      (reset),
        .x_val      (x_val),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .draw_done  (draw_done)
    );

    always #5 clock = ~clock;

`ifdef SPRITE_MASK_EN
    logic [7:0] mrow [8] = '{8'h18, 8'h3C, 8'h7E, 8'hDB, 8'hFF, 8'h24, 8'h5A, 8'hA5};
`endif

    function automatic bit mask_on(input int r, input int c);
`ifdef SPRITE_MASK_EN
        logic [7:0] b;
        b = mrow[r];
        return b[7-c];
`else
        return (r < SPRITE_H) && (c < SPRITE_W);
`endif
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Expected outputs indexed by posedge number: what must be visible after that edge
    bit         exp_plot [MAXC];
    bit         exp_busy [MAXC];
    bit         exp_done [MAXC];
    logic [7:0] exp_x    [MAXC];
    logic [6:0] exp_y    [MAXC];
    logic [2:0] exp_col  [MAXC];

    int cyc     = 0;
    int m_free  = 0;
    int m_last  = 0;
    int m_n     = 0;
    bit m_first = 1'b1;

    task automatic sched(input int t0, input int base, input bit erase);
        int r, c, sx, e;
        for (int p = 0; p < NPIX; p++) begin
            r  = p / SPRITE_W;
            c  = p % SPRITE_W;
            sx = base + c;
            e  = t0 + 2 + p;
            if (e < MAXC) begin
                exp_plot[e] = (sx < SCREEN_W) && (erase || mask_on(r, c));
                exp_x[e]    = 8'(sx);
                exp_y[e]    = 7'(ENEMY_Y + r);
                exp_col[e]  = erase ? 3'b000 : 3'b100;
            end
        end
    endtask

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            for (int i = cyc; i < cyc + 300 && i < MAXC; i++) begin
                exp_plot[i] = 1'b0;
                exp_busy[i] = 1'b0;
                exp_done[i] = 1'b0;
            end
            m_first = 1'b1;
            m_last  = 0;
            m_free  = cyc + 1;
        end else if (cyc >= m_free && (m_first || int'(x_val) != m_last)) begin
            m_n = m_first ? NPIX : 2 * NPIX;
            if (!m_first) sched(cyc, m_last, 1'b1);
            sched(cyc + (m_first ? 0 : NPIX), int'(x_val), 1'b0);
            for (int i = cyc; i <= cyc + m_n + 2 && i < MAXC; i++) exp_busy[i] = 1'b1;
            if (cyc + m_n + 2 < MAXC) exp_done[cyc + m_n + 2] = 1'b1;
            m_first = 1'b0;
            m_last  = int'(x_val);
            m_free  = cyc + m_n + 1;
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            chk("rst_plot", vga_plot, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", draw_done, 0);
            chk("rst_x", vga_x, 0);
            chk("rst_y", vga_y, 0);
            chk("rst_colour", vga_colour, 0);
        end else if (cyc < MAXC) begin
            chk("plot", vga_plot, exp_plot[cyc]);
            chk("busy", busy, exp_busy[cyc]);
            chk("draw_done", draw_done, exp_done[cyc]);
            if (exp_plot[cyc]) begin
                chk("vga_x", vga_x, exp_x[cyc]);
                chk("vga_y", vga_y, exp_y[cyc]);
                chk("vga_colour", vga_colour, exp_col[cyc]);
            end
        end
    end

    int n_bg, n_fg, n_done, fg_first_x, fg_first_y, fg_last_x, fg_last_y, fg_max_x;

    always @(negedge clock) begin
        if (!reset) begin
            if (vga_plot) begin
                if (vga_colour == 3'b000) begin
                    n_bg++;
                end else begin
                    if (n_fg == 0) begin
                        fg_first_x = vga_x;
                        fg_first_y = vga_y;
                    end
                    n_fg++;
                    fg_last_x = vga_x;
                    fg_last_y = vga_y;
                    if (int'(vga_x) > fg_max_x) fg_max_x = vga_x;
                end
            end
            if (draw_done) n_done++;
        end
    end

    task automatic clear_mon();
        n_bg = 0; n_fg = 0; n_done = 0;
        fg_first_x = -1; fg_first_y = -1; fg_last_x = -1; fg_last_y = -1; fg_max_x = -1;
    endtask

    task automatic wait_idle();
        int k;
        repeat (2) @(negedge clock);
        k = 0;
        while (busy && k < 1000) begin
            @(negedge clock);
            k++;
        end
        chk("idle_timeout", busy, 0);
        #1;
    endtask

    initial begin
        int lat, k;
        clear_mon();
        reset = 1'b1;
        x_val = 8'd0;
        repeat (3) @(negedge clock);
        #1;
        clear_mon();
        reset = 1'b0;

        // First draw after reset: no erase
        wait_idle();
        chk("first_bg", n_bg, 0);
        chk("first_fg", n_fg, FG_FULL);
        chk("first_x0", fg_first_x, FIRST_COL);
        chk("first_y0", fg_first_y, 4);
        chk("first_xlast", fg_last_x, 7);
        chk("first_ylast", fg_last_y, 11);
        chk("first_done", n_done, 1);
        chk("first_busy_low", busy, 0);

        // Move 0 -> 1 and measure latency to first plot
        clear_mon();
        x_val = 8'd1;
        lat = 0;
        do begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end while (!vga_plot && lat < 20);
        chk("plot_latency", lat, 3);
        wait_idle();
        chk("move_bg", n_bg, 64);
        chk("move_fg", n_fg, FG_FULL);
        chk("move_x0", fg_first_x, 1 + FIRST_COL);
        chk("move_done", n_done, 1);

        // Right-edge clipping
        clear_mon();
        x_val = 8'd158;
        wait_idle();
        chk("clip_bg", n_bg, 64);
        chk("clip_fg", n_fg, FG_EDGE);
        chk("clip_maxx", fg_max_x, 159);
        chk("clip_done", n_done, 1);

        // Unchanged position produces nothing
        clear_mon();
        repeat (10) @(negedge clock);
        #1;
        chk("same_busy", busy, 0);
        chk("same_plots", n_bg + n_fg, 0);

        // Positions arriving while busy collapse to the latest one
        x_val = 8'd10;
        wait_idle();
        clear_mon();
        x_val = 8'd11;
        repeat (10) @(negedge clock);
        #1 x_val = 8'd12;
        repeat (10) @(negedge clock);
        #1 x_val = 8'd13;
        wait_idle();
        chk("skip_done", n_done, 2);
        chk("skip_bg", n_bg, 128);
        chk("skip_fg", n_fg, 2 * FG_FULL);
        chk("skip_x0", fg_first_x, 11 + FIRST_COL);
        chk("skip_xlast", fg_last_x, 20);

        // Asynchronous reset in the middle of DRAW
        clear_mon();
        x_val = 8'd50;
        k = 0;
        while (n_fg < 30 && k < 400) begin
            @(negedge clock);
            k++;
        end
        chk("reach_px30", int'(n_fg >= 30), 1);
        #1 reset = 1'b1;
        #1;
        chk("async_plot", vga_plot, 0);
        chk("async_busy", busy, 0);
        chk("async_x", vga_x, 0);
        chk("async_done", draw_done, 0);
        repeat (2) @(negedge clock);
        #1;
        clear_mon();
        reset = 1'b0;
        wait_idle();
        chk("rdraw_bg", n_bg, 0);
        chk("rdraw_fg", n_fg, FG_FULL);
        chk("rdraw_x0", fg_first_x, 50 + FIRST_COL);
        chk("rdraw_done", n_done, 1);

        // Randomized positions, dwell times and occasional resets
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) != 0) x_val = 8'($urandom_range(0, 161));
            repeat ($urandom_range(1, 160)) @(negedge clock);
            #1;
            if ($urandom_range(0, 14) == 0) begin
                reset = 1'b1;
                repeat (2) @(negedge clock);
                #1 reset = 1'b0;
            end
        end
        wait_idle();
        repeat (3) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
